// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the core's fetch/load-store ports, the arbiter and the unified memory.
// The slave modport is the arbiter's view; the master modport is the surrounding environment
// (core ports plus memory) that drives requests and memory responses.
interface riscv_mem_arbiter_if;
  // Instruction fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  // Load/store data port
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  // Unified memory port
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_size, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_gnt, m_rvalid, m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_size, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_gnt, m_rvalid, m_rdata
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Fetch / load-store arbiter in front of a single-port unified memory.
// Data has priority except when fetch has been starved for STARVE_LIMIT grants. A source
// presented to memory but not yet granted is held so it cannot be preempted. A small FIFO of
// source bits routes the in-order memory responses back. Misaligned or reserved-size data
// accesses never reach memory; they are answered locally with d_err once memory is idle.
module riscv_mem_arbiter #(
  parameter int unsigned MAX_OUTST    = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic               clk,
  input logic               rst_n,
  riscv_mem_arbiter_if.slave bus
);

  localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTST) + 1;
  localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    SrcFetch = 1'b0,
    SrcData  = 1'b1
  } src_e;

  // State
  logic [MAX_OUTST-1:0] fifo_q;     // 1 = entry belongs to the data port
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 hold_q, hold_d;
  src_e                 hold_src_q, hold_src_d;
  logic [StvW-1:0]      starve_q, starve_d;
  logic                 err_q, err_d;

  // Combinational
  logic        size_bad;
  logic        d_illegal;
  logic        d_legal;
  logic        fetch_force;
  logic        sel_valid;
  src_e        sel;
  logic        fifo_full;
  logic        fifo_empty;
  logic        mem_req;
  logic        push;
  logic        pop;
  logic        head_data;
  logic        err_accept;
  logic        i_grant;
  logic        d_grant_mem;
  logic        d_grant;
  logic [3:0]  d_be;
  logic [31:0] d_wdata_rep;
  logic [31:0] i_addr_al;
  logic [31:0] d_addr_al;

  // Classify the data access and build its byte enables and lane-replicated write data
  always_comb begin
    size_bad    = 1'b0;
    d_be        = 4'hF;
    d_wdata_rep = bus.d_wdata;
    unique case (bus.d_size)
      2'd0: begin
        size_bad    = 1'b0;
        d_be        = 4'b0001 << bus.d_addr[1:0];
        d_wdata_rep = {4{bus.d_wdata[7:0]}};
      end
      2'd1: begin
        size_bad    = bus.d_addr[0];
        d_be        = bus.d_addr[1] ? 4'b1100 : 4'b0011;
        d_wdata_rep = {2{bus.d_wdata[15:0]}};
      end
      2'd2: begin
        size_bad = 1'b1;
      end
      2'd3: begin
        size_bad    = (bus.d_addr[1:0] != 2'b00);
        d_be        = 4'hF;
        d_wdata_rep = bus.d_wdata;
      end
    endcase
  end

  assign d_illegal   = bus.d_req && size_bad;
  assign d_legal     = bus.d_req && !size_bad;
  assign fetch_force = bus.i_req && (starve_q == StvW'(STARVE_LIMIT));

  // Pick the source for the memory port; a held selection always wins
  always_comb begin
    sel       = SrcFetch;
    sel_valid = 1'b0;
    if (hold_q) begin
      sel       = hold_src_q;
      sel_valid = 1'b1;
    end else if (d_legal && !fetch_force) begin
      sel       = SrcData;
      sel_valid = 1'b1;
    end else if (bus.i_req) begin
      sel       = SrcFetch;
      sel_valid = 1'b1;
    end
  end

  // Full is taken from the registered count so a same-cycle pop cannot admit a push
  assign fifo_full   = (cnt_q == CntW'(MAX_OUTST));
  assign fifo_empty  = (cnt_q == '0);
  assign mem_req     = sel_valid && !fifo_full;
  assign push        = mem_req && bus.m_gnt;
  assign pop         = bus.m_rvalid && !fifo_empty;
  assign head_data   = fifo_q[rd_ptr_q];
  assign i_grant     = push && (sel == SrcFetch);
  assign d_grant_mem = push && (sel == SrcData);
  // Local error response only when no memory response can collide with it next cycle
  assign err_accept  = d_illegal && fifo_empty && !bus.m_rvalid;
  assign d_grant     = d_grant_mem || err_accept;

  assign i_addr_al = bus.i_addr & 32'hFFFF_FFFC;
  assign d_addr_al = bus.d_addr & 32'hFFFF_FFFC;

  // Port outputs
  assign bus.i_gnt    = i_grant;
  assign bus.i_rvalid = pop && !head_data;
  assign bus.i_rdata  = (pop && !head_data) ? bus.m_rdata : '0;
  assign bus.d_gnt    = d_grant;
  assign bus.d_rvalid = (pop && head_data) || err_q;
  assign bus.d_err    = err_q;
  assign bus.d_rdata  = (pop && head_data) ? bus.m_rdata : '0;

  // Memory outputs are driven only while a request is presented
  assign bus.m_req   = mem_req;
  assign bus.m_we    = mem_req && (sel == SrcData) && bus.d_we;
  assign bus.m_be    = !mem_req ? 4'h0 : ((sel == SrcData) ? d_be : 4'hF);
  assign bus.m_addr  = !mem_req ? '0 : ((sel == SrcData) ? d_addr_al : i_addr_al);
  assign bus.m_wdata = (mem_req && (sel == SrcData)) ? d_wdata_rep : '0;

  // Next state for the outstanding FIFO, hold bit, starvation counter and error response
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    hold_d     = mem_req && !bus.m_gnt;
    hold_src_d = sel;
    starve_d   = starve_q;
    err_d      = err_accept;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntW'(1);
    end

    if (i_grant || !bus.i_req) begin
      starve_d = '0;
    end else if (d_grant && (starve_q != StvW'(STARVE_LIMIT))) begin
      starve_d = starve_q + StvW'(1);
    end
  end

  // State registers; reset drops every outstanding entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      hold_q     <= 1'b0;
      hold_src_q <= SrcFetch;
      starve_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= (sel == SrcData);
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      hold_src_q <= hold_src_d;
      starve_q   <= starve_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Testbench for riscv_mem_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a transaction-level model (queue of outstanding sources, starvation count).
module tb_riscv_mem_arbiter;

  localparam int unsigned MaxOutst    = 4;
  localparam int unsigned StarveLimit = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  riscv_mem_arbiter_if bus ();

  riscv_mem_arbiter #(
    .MAX_OUTST   (MaxOutst),
    .STARVE_LIMIT(StarveLimit)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  bit out_q[$];  // outstanding memory transactions, 1 = data port
  int starve;
  bit held_v;
  bit held_src;
  bit err_pend;
  bit last_i_gnt;
  bit last_d_gnt;

  // Observed DUT values from the latest cycle, for directed checks
  logic        obs_i_gnt, obs_d_gnt, obs_m_req, obs_m_we;
  logic [3:0]  obs_m_be;
  logic [31:0] obs_m_addr, obs_m_wdata;
  logic        obs_i_rvalid, obs_d_rvalid, obs_d_err;
  logic [31:0] obs_i_rdata, obs_d_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_req    = 1'b0;
    bus.i_addr   = '0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_size   = 2'd0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = '0;
  endtask

  task automatic model_reset();
    out_q.delete();
    starve     = 0;
    held_v     = 1'b0;
    held_src   = 1'b0;
    err_pend   = 1'b0;
    last_i_gnt = 1'b0;
    last_d_gnt = 1'b0;
  endtask

  // Called just after a rising edge; asserts reset asynchronously and checks idle outputs
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #4;
    check_eq("rst_i_gnt", bus.i_gnt, 0);
    check_eq("rst_i_rvalid", bus.i_rvalid, 0);
    check_eq("rst_i_rdata", bus.i_rdata, 0);
    check_eq("rst_d_gnt", bus.d_gnt, 0);
    check_eq("rst_d_rvalid", bus.d_rvalid, 0);
    check_eq("rst_d_rdata", bus.d_rdata, 0);
    check_eq("rst_d_err", bus.d_err, 0);
    check_eq("rst_m_req", bus.m_req, 0);
    check_eq("rst_m_we", bus.m_we, 0);
    check_eq("rst_m_be", bus.m_be, 0);
    check_eq("rst_m_addr", bus.m_addr, 0);
    check_eq("rst_m_wdata", bus.m_wdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic mem_rand(input int gnt_pct, input int rv_pct);
    bus.m_gnt    = ($urandom % 100) < gnt_pct;
    bus.m_rvalid = (out_q.size() > 0) && (($urandom % 100) < rv_pct);
    bus.m_rdata  = $urandom;
  endtask

  // One cycle: inputs already applied; compare at the falling edge, advance the model
  task automatic step();
    bit          illegal, present, src, mreq, push, pop, head, err_acc, igx, dgx, iv, dv;
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    logic        ewe;
    #4;
    illegal = bus.d_req && ((bus.d_size == 2'd2) ||
                            (bus.d_size == 2'd1 && bus.d_addr[0]) ||
                            (bus.d_size == 2'd3 && bus.d_addr[1:0] != 2'b00));
    if (held_v) begin
      present = 1'b1;
      src     = held_src;
    end else if (bus.d_req && !illegal && !(bus.i_req && starve == StarveLimit)) begin
      present = 1'b1;
      src     = 1'b1;
    end else if (bus.i_req) begin
      present = 1'b1;
      src     = 1'b0;
    end else begin
      present = 1'b0;
      src     = 1'b0;
    end
    mreq = present && (out_q.size() < MaxOutst);
    if (src) begin
      ea  = bus.d_addr & 32'hFFFF_FFFC;
      ewe = bus.d_we;
      case (bus.d_size)
        2'd0: begin
          eb = 4'(1 << bus.d_addr[1:0]);
          ew = (bus.d_wdata & 32'hFF) * 32'h0101_0101;
        end
        2'd1: begin
          eb = bus.d_addr[1] ? 4'hC : 4'h3;
          ew = (bus.d_wdata & 32'hFFFF) * 32'h0001_0001;
        end
        default: begin
          eb = 4'hF;
          ew = bus.d_wdata;
        end
      endcase
    end else begin
      ea  = bus.i_addr & 32'hFFFF_FFFC;
      ewe = 1'b0;
      eb  = 4'hF;
      ew  = '0;
    end
    push    = mreq && bus.m_gnt;
    igx     = push && !src;
    err_acc = illegal && (out_q.size() == 0) && !bus.m_rvalid;
    dgx     = (push && src) || err_acc;
    pop     = bus.m_rvalid && (out_q.size() > 0);
    head    = pop ? out_q[0] : 1'b0;
    iv      = pop && !head;
    dv      = (pop && head) || err_pend;

    obs_i_gnt    = bus.i_gnt;
    obs_d_gnt    = bus.d_gnt;
    obs_m_req    = bus.m_req;
    obs_m_we     = bus.m_we;
    obs_m_be     = bus.m_be;
    obs_m_addr   = bus.m_addr;
    obs_m_wdata  = bus.m_wdata;
    obs_i_rvalid = bus.i_rvalid;
    obs_i_rdata  = bus.i_rdata;
    obs_d_rvalid = bus.d_rvalid;
    obs_d_rdata  = bus.d_rdata;
    obs_d_err    = bus.d_err;

    check_eq("m_req", bus.m_req, mreq);
    if (mreq) begin
      check_eq("m_addr", bus.m_addr, ea);
      check_eq("m_we", bus.m_we, ewe);
      check_eq("m_be", bus.m_be, eb);
      if (src) check_eq("m_wdata", bus.m_wdata, ew);
    end
    check_eq("i_gnt", bus.i_gnt, igx);
    check_eq("d_gnt", bus.d_gnt, dgx);
    check_eq("i_rvalid", bus.i_rvalid, iv);
    if (iv) check_eq("i_rdata", bus.i_rdata, bus.m_rdata);
    check_eq("d_rvalid", bus.d_rvalid, dv);
    check_eq("d_err", bus.d_err, err_pend);
    if (dv) check_eq("d_rdata", bus.d_rdata, err_pend ? 32'h0 : bus.m_rdata);

    if (pop) void'(out_q.pop_front());
    if (push) out_q.push_back(src);
    held_v   = mreq && !bus.m_gnt;
    held_src = src;
    if (igx || !bus.i_req) starve = 0;
    else if (dgx && starve < StarveLimit) starve++;
    err_pend   = err_acc;
    last_i_gnt = igx;
    last_d_gnt = dgx;
    @(posedge clk);
    #1;
  endtask

  // Drop requests and answer everything outstanding
  task automatic drain();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.m_gnt = 1'b0;
    for (int k = 0; k < 16 && out_q.size() > 0; k++) begin
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = $urandom;
      step();
    end
    bus.m_rvalid = 1'b0;
    step();
    check_eq("drain_empty", out_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] seq;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Fetch only, response two cycles after the grant
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    bus.m_gnt  = 1'b1;
    step();
    check_eq("fetch_gnt", obs_i_gnt, 1);
    check_eq("fetch_addr", obs_m_addr, 32'h100);
    bus.i_req = 1'b0;
    bus.m_gnt = 1'b0;
    step();
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'hDEAD_BEEF;
    step();
    check_eq("fetch_rvalid", obs_i_rvalid, 1);
    check_eq("fetch_rdata", obs_i_rdata, 32'hDEAD_BEEF);
    bus.m_rvalid = 1'b0;

    // Both ports requesting continuously: D,D,D,I,D,D,D,I
    seq         = '0;
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h200;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_size  = 2'd3;
    bus.d_addr  = 32'h300;
    bus.m_gnt   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.m_rvalid = out_q.size() > 0;
      bus.m_rdata  = $urandom;
      step();
      seq = {seq[6:0], obs_d_gnt};
    end
    check_eq("starve_order", seq, 8'hEE);
    drain();

    // Store byte at 0x1003
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_size  = 2'd0;
    bus.d_addr  = 32'h1003;
    bus.d_wdata = 32'hAB;
    bus.m_gnt   = 1'b1;
    step();
    check_eq("sb_gnt", obs_d_gnt, 1);
    check_eq("sb_be", obs_m_be, 4'b1000);
    check_eq("sb_wdata", obs_m_wdata, 32'hABAB_ABAB);
    check_eq("sb_addr", obs_m_addr, 32'h1000);
    bus.d_req    = 1'b0;
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b1;
    step();
    check_eq("sb_rvalid", obs_d_rvalid, 1);
    check_eq("sb_err", obs_d_err, 0);
    bus.m_rvalid = 1'b0;

    // Misaligned store word: never reaches memory, error response next cycle
    bus.d_req  = 1'b1;
    bus.d_size = 2'd3;
    bus.d_addr = 32'h1002;
    bus.m_gnt  = 1'b1;
    step();
    check_eq("sw_mis_mreq", obs_m_req, 0);
    check_eq("sw_mis_gnt", obs_d_gnt, 1);
    bus.d_req = 1'b0;
    step();
    check_eq("sw_mis_rvalid", obs_d_rvalid, 1);
    check_eq("sw_mis_err", obs_d_err, 1);
    check_eq("sw_mis_rdata", obs_d_rdata, 0);

    // Illegal access waits behind an outstanding fetch and a same-cycle response
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h400;
    step();
    bus.i_req  = 1'b0;
    bus.d_req  = 1'b1;
    bus.d_size = 2'd2;
    bus.d_addr = 32'h2000;
    step();
    check_eq("err_wait", obs_d_gnt, 0);
    bus.m_rvalid = 1'b1;
    step();
    check_eq("err_wait_rv", obs_d_gnt, 0);
    check_eq("err_wait_irv", obs_i_rvalid, 1);
    bus.m_rvalid = 1'b0;
    step();
    check_eq("err_accept", obs_d_gnt, 1);
    bus.d_req = 1'b0;
    step();
    check_eq("err_resp", obs_d_err, 1);

    // Held fetch is not preempted by a later data request
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h500;
    bus.m_gnt  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("hold_addr", obs_m_addr, 32'h500);
    end
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_size = 2'd3;
    bus.d_addr = 32'h600;
    step();
    check_eq("hold_preempt", obs_m_addr, 32'h500);
    check_eq("hold_no_dgnt", obs_d_gnt, 0);
    bus.m_gnt = 1'b1;
    step();
    check_eq("hold_igrant", obs_i_gnt, 1);
    bus.i_req = 1'b0;
    step();
    check_eq("hold_then_d", obs_d_gnt, 1);
    drain();

    // Fill the FIFO with mixed sources, fifth request blocked until a slot frees
    bus.m_gnt = 1'b1;
    bus.d_we  = 1'b0;
    bus.d_size = 2'd3;
    for (int k = 0; k < 4; k++) begin
      bus.i_req  = (k % 2 == 0);
      bus.d_req  = (k % 2 == 1);
      bus.i_addr = 32'h700 + 32'(k * 4);
      bus.d_addr = 32'h800 + 32'(k * 4);
      step();
      check_eq("fill_gnt", obs_i_gnt | obs_d_gnt, 1);
    end
    bus.i_req  = 1'b0;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h900;
    step();
    check_eq("full_block", obs_m_req, 0);
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h1111_1111;
    step();
    check_eq("full_pop_route", obs_i_rvalid, 1);
    check_eq("full_same_cycle", obs_m_req, 0);
    bus.m_rvalid = 1'b0;
    step();
    check_eq("full_freed", obs_m_req, 1);
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h2222_2222;
    bus.d_req    = 1'b0;
    step();
    check_eq("mixed_d_route", obs_d_rvalid, 1);
    check_eq("mixed_d_data", obs_d_rdata, 32'h2222_2222);
    drain();

    // Reset with a transaction outstanding; its late response is ignored
    bus.i_req  = 1'b1;
    bus.i_addr = 32'hA00;
    bus.m_gnt  = 1'b1;
    step();
    do_reset();
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h3333_3333;
    step();
    check_eq("rst_drop", obs_i_rvalid, 0);
    bus.m_rvalid = 1'b0;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (!(bus.i_req && !last_i_gnt)) begin
        bus.i_req  = ($urandom % 100) < 50;
        bus.i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!(bus.d_req && !last_d_gnt)) begin
        bus.d_req   = ($urandom % 100) < 50;
        bus.d_we    = 1'($urandom % 2);
        bus.d_size  = 2'($urandom % 4);
        bus.d_addr  = $urandom;
        if ($urandom % 2 == 0) bus.d_addr[1:0] = 2'b00;
        bus.d_wdata = $urandom;
      end
      mem_rand(70, 40);
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
